mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 MEM_R_EN  input  1  load request from EXE stage.
REQ-005 MEM_W_EN  input  1  store request from EXE stage.
REQ-006 WB_EN  input  1  instruction writes a register.
REQ-007 ALU_Result  input  32  ALU result; memory byte address for loads and stores.
REQ-008 ST_val  input  32  store data.
REQ-009 Dest  input  5  destination register number.
REQ-010 sram_req  output  1  memory request valid.
REQ-011 sram_we  output  1  1 = write, 0 = read.
REQ-012 sram_addr  output  32  memory address.
REQ-013 sram_wdata  output  32  memory write data.
REQ-014 sram_rdata  input  32  memory read data; valid when sram_ready=1.
REQ-015 sram_ready  input  1  one-cycle pulse that completes the outstanding request.
REQ-016 freeze  output  1  stall to upstream stages; 1 = hold current instruction.
REQ-017 WB_Write_Enable, WB_Dest[4:0], WB_Data[31:0]  outputs  write-back bus to ID-stage register file.

Function
REQ-018 SHALL use FSM states IDLE, BUSY_RD and BUSY_WR.
REQ-019 IDLE with MEM_R_EN=1 -> capture ALU_Result, Dest and WB_EN; go to BUSY_RD. MEM_R_EN has priority when MEM_R_EN=MEM_W_EN=1.
REQ-020 IDLE with only MEM_W_EN=1 -> capture ALU_Result and ST_val; go to BUSY_WR.
REQ-021 In BUSY_* states, drive sram_req=1 and present registered sram_addr/sram_wdata; sram_we=1 only in BUSY_WR; all sram_* outputs SHALL be 0 in IDLE.
REQ-022 Combinational freeze = (IDLE and (MEM_R_EN or MEM_W_EN)) or (BUSY_* and not sram_ready).
REQ-023 In BUSY_*, inputs are ignored; sram_ready=1 -> return to IDLE on the next edge.
REQ-024 Non-memory instruction in IDLE: WB_Write_Enable<=WB_EN, WB_Dest<=Dest, WB_Data<=ALU_Result on the next edge (latency 1 cycle).
REQ-025 BUSY_RD with sram_ready=1: WB_Write_Enable<=captured WB_EN, WB_Dest<=captured Dest, WB_Data<=sram_rdata (latency = ready cycle + 1).
REQ-026 All other cycles (IDLE capture cycle, BUSY_* waiting, BUSY_WR completion) -> WB_Write_Enable<=0; WB_Dest and WB_Data hold.
REQ-027 sram_ready while in IDLE SHALL be ignored.
REQ-028 Addresses pass through unmodified (32-bit, no alignment check).

Reset
REQ-029 rst=0 -> state IDLE; WB_Write_Enable=0; WB_Dest=0; WB_Data=0; all captured registers=0, immediately and independent of clk.
REQ-030 Reset mid-transaction SHALL abandon the request: sram_req=0 and no write-back for it; sram_ready arriving after reset release is ignored per REQ-027.

Configuration
REQ-031 Macro MEM_WB_ZERO_REG_GUARD_EN: when defined, WB_Write_Enable SHALL be forced 0 whenever the destination being written is 0; when undefined, write-back to register 0 passes through unchanged.

Verification
REQ-032 ALU op: WB_EN=1, Dest=5, ALU_Result=0x1234 -> next cycle WB_Write_Enable=1, WB_Dest=5, WB_Data=0x1234, freeze=0 throughout.
REQ-033 Load: MEM_R_EN=1, addr 0x40, Dest=7; sram_ready after 3 wait cycles with rdata 0xDEADBEEF -> freeze high 4 cycles; sram_req/we=1/0 at 0x40; write-back 7 <- 0xDEADBEEF one cycle after ready.
REQ-034 Store: MEM_W_EN=1, addr 0x80, ST_val 0xA5A5A5A5, immediate ready -> sram_we=1, sram_wdata=0xA5A5A5A5 for one cycle; WB_Write_Enable stays 0.
REQ-035 Reset asserted during BUSY_RD -> state IDLE, sram_req=0, WB outputs 0 at once; late sram_ready causes no write-back.
REQ-036 ALU op Dest=0, WB_EN=1 -> WB_Write_Enable=0 with MEM_WB_ZERO_REG_GUARD_EN defined, 1 without it.
REQ-037 MEM_R_EN=MEM_W_EN=1 in IDLE -> read issued (sram_we=0).

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and write-back stage with a single-outstanding SRAM handshake.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   MEM_R_EN, MEM_W_EN, WB_EN         load / store / register-write flags from EXE
//   ALU_Result, ST_val, Dest          address or result, store data, destination register
//   sram_req, sram_we                 request valid, 1 = write
//   sram_addr, sram_wdata             registered request address and write data
//   sram_rdata, sram_ready            read data and one-cycle completion pulse
//   freeze                            stall upstream while a request is pending
//   WB_Write_Enable, WB_Dest, WB_Data write-back bus to the register file
// Build option: define MEM_WB_ZERO_REG_GUARD_EN to suppress write-back to register 0.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        WB_EN,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] ST_val,
    input  logic [4:0]  Dest,
    output logic        sram_req,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready,
    output logic        freeze,
    output logic        WB_Write_Enable,
    output logic [4:0]  WB_Dest,
    output logic [31:0] WB_Data
);
`ifdef MEM_WB_ZERO_REG_GUARD_EN
    localparam bit ZERO_GUARD = 1'b1;
`else
    localparam bit ZERO_GUARD = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR} state_t;
    state_t      state;
    logic [31:0] addr_q, wdata_q;
    logic [4:0]  dest_q;
    logic        wb_en_q;
    logic        busy;
    assign busy       = state != IDLE;
    assign sram_req   = busy;
    assign sram_we    = state == BUSY_WR;
    assign sram_addr  = busy ? addr_q : 32'd0;
    assign sram_wdata = busy ? wdata_q : 32'd0;
    assign freeze     = busy ? !sram_ready : (MEM_R_EN || MEM_W_EN);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            dest_q          <= '0;
            wb_en_q         <= 1'b0;
            WB_Write_Enable <= 1'b0;
            WB_Dest         <= '0;
            WB_Data         <= '0;
        end else begin
            WB_Write_Enable <= 1'b0;
            case (state)
                IDLE: begin
                    // read wins when both memory flags are raised
                    if (MEM_R_EN) begin
                        state   <= BUSY_RD;
                        addr_q  <= ALU_Result;
                        dest_q  <= Dest;
                        wb_en_q <= WB_EN;
                    end else if (MEM_W_EN) begin
                        state   <= BUSY_WR;
                        addr_q  <= ALU_Result;
                        wdata_q <= ST_val;
                    end else begin
                        WB_Write_Enable <= WB_EN && !(ZERO_GUARD && Dest == 5'd0);
                        WB_Dest         <= Dest;
                        WB_Data         <= ALU_Result;
                    end
                end
                BUSY_RD: if (sram_ready) begin
                    state           <= IDLE;
                    WB_Write_Enable <= wb_en_q && !(ZERO_GUARD && dest_q == 5'd0);
                    WB_Dest         <= dest_q;
                    WB_Data         <= sram_rdata;
                end
                BUSY_WR: if (sram_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
